hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the CPU's fixed MEM/WB forwarding unit. It tracks every register-writing instruction in flight after EX in a shift-register scoreboard. For each EX source operand it generates a per-operand forward select, and it raises a single stall when the youngest producer's data is not yet available. It supports configurable load latency, operand count and a forwarding-disabled mode, and sits beside the EX stage of the pipelined core.

## Interface
- `REG_W`, 5: register address width; the MSB selects the vector file and takes part in matching like any other bit.
- `NUM_SRC`, 2: source operands checked per EX instruction.
- `LOAD_LAT`, 1: cycles after MEM entry before load data is forwardable. Minimum 1.
- `FWD_EN`, 1: 1 = forward from slots; 0 = stall until producer retires.
- `ZERO_SKIP`, 1: 1 = address 0 never matches (hardwired zero).
- Derived: `DEPTH` = `LOAD_LAT`+1 slots; `SEL_W` = $clog2(`DEPTH`+1).
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous and active-high.
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_flush`  in  1  EX instruction is killed this cycle.
- `ex_rd`  in  `REG_W`  EX destination.
- `ex_we`  in  1  EX instruction writes `ex_rd`.
- `ex_ld`  in  1  EX instruction is a load (scalar or vector).
- `ex_rs`  in  `NUM_SRC`x`REG_W`  EX source addresses.
- `ex_rs_used`  in  `NUM_SRC`  source i is actually read.
- `stall`  out  1  hold IF/ID/EX and insert a bubble into slot 1.
- `fwd_sel`  out  `NUM_SRC`x`SEL_W`  0 = register-file/ID operand; k = result held by slot k.
- `stall_cnt`  out  32  saturating count of stalled cycles.

## Operation
- Slot k (1..`DEPTH`) holds {valid, rd, we, ld} of the instruction k stages past EX. Slot 1 = MEM; slot `DEPTH` = WB, the last forwardable stage.
- Shift every cycle: slot k+1 <= slot k. Slot 1 <= EX instruction only if `ex_valid` & !`ex_flush` & !`stall`; otherwise slot 1 <= bubble. Older slots shift even while stalled.
- Match for source i at slot k: `ex_rs_used`[i], slot valid, slot we, rd == `ex_rs`[i]. If `ZERO_SKIP`, rd != 0 is also required.
- Producer for source i = the matching slot with the smallest k (youngest). Younger producers shadow older ones.
- Ready(k) = !ld | (k >= `LOAD_LAT`+1). Non-loads are ready from slot 1.
- `FWD_EN`=1: if the producer is ready, `fwd_sel`[i]=k; otherwise `fwd_sel`[i]=0 and that source requests a stall.
- `FWD_EN`=0: any match requests a stall and `fwd_sel` is always 0. The stall lasts until the producer leaves slot `DEPTH`; the register file is write-first, so the ID read is then correct.
- `stall` = OR of the per-source requests, gated by `ex_valid` & !`ex_flush`. Flush beats stall.
- `stall_cnt` increments on each cycle with `stall`=1 and saturates at 2^32-1.

## Timing
- `stall` and `fwd_sel` are combinational from EX inputs and registered slot state. The slot update is registered on `clk`.
- Reset: all slots invalid, `stall_cnt`=0. With no valid slots, `stall`=0 and `fwd_sel`=0 for every input.
- A reset mid-operation discards all in-flight tracking. The next cycle behaves as cold start.
- ALU producer directly ahead of its consumer: 0 stall cycles, `fwd_sel`=1.
- Load-use with `FWD_EN`=1: exactly `LOAD_LAT` stall cycles, then `fwd_sel`=`LOAD_LAT`+1.
- `FWD_EN`=0: a dependent on slot k stalls `DEPTH`-k+1 cycles.
- Two sources matching different slots are resolved independently. A stall from either source holds both.
- The instruction in EX never matches itself; only slots are searched.

## Structure
- Package `hazard_pkg`: slot struct {valid, rd, we, ld} and a `FWD_REGFILE`=0 constant. Shared with the core top and with operand-mux sizing.
- One sub-module, `src_resolve`, instantiated `NUM_SRC` times. It takes one source against all slots and outputs {sel, stall_req}.
- The top holds the slot shift register, the stall OR and the counter.

## Test plan
- Defaults; `add r3` in EX, next cycle `sub` reads r3 -> `stall`=0, `fwd_sel`[0]=1.
- Defaults; `ld r4`, then a consumer of r4 -> 1 cycle `stall`=1 (fwd 0), then `fwd_sel`=2. `stall_cnt`=1.
- `LOAD_LAT`=3; load then immediate consumer -> 3 stall cycles, then `fwd_sel`=4.
- Writes to r5 in slots 1 and 2 -> `fwd_sel`=1 (youngest wins). Read of r0 with a pending write to r0 -> `fwd_sel`=0, no stall.
- `FWD_EN`=0; ALU r6 then consumer -> 2 stall cycles, `fwd_sel` always 0. Vector r16 vs scalar r0 -> no match.
- Stall pending and `ex_flush`=1 -> `stall`=0, slot 1 bubble. Assert `rst` during a load-use stall -> next cycle `stall`=0, `stall_cnt`=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard, the core top and operand-mux sizing.
package hazard_pkg;

  // fwd_sel value meaning "take the register-file / ID-stage operand".
  localparam int FWD_REGFILE = 0;

  // Storage width of a tracked destination. Instances use REG_W <= RD_W_MAX;
  // narrower addresses are zero-extended, so unused upper bits never differ.
  localparam int RD_W_MAX = 8;

  // One in-flight instruction past EX.
  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rd;
    logic                we;
    logic                ld;
  } slot_t;

endpackage

// File: rtl/src_resolve.sv
// Resolves one EX source operand against every scoreboard slot: picks the
// youngest producer and decides between forwarding from it and stalling.
module src_resolve
  import hazard_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int DEPTH     = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FWD_EN    = 1,
  parameter int ZERO_SKIP = 1,
  parameter int SEL_W     = 2
) (
  input  logic [REG_W-1:0]  rs_i,
  input  logic              rs_used_i,
  input  slot_t [DEPTH-1:0] slots_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              stall_req_o
);

  logic             found;
  logic [SEL_W-1:0] prod_k;
  logic             prod_ld;
  logic             ready;
  logic             zero_blk;

  // Address 0 is hardwired zero when ZERO_SKIP is set, so it never matches.
  assign zero_blk = (ZERO_SKIP != 0) && (rs_i == '0);

  // Youngest-producer search: scan oldest to youngest so the smallest k wins.
  always_comb begin
    found   = 1'b0;
    prod_k  = '0;
    prod_ld = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (rs_used_i && !zero_blk && slots_i[k-1].valid && slots_i[k-1].we &&
          (slots_i[k-1].rd == RD_W_MAX'(rs_i))) begin
        found   = 1'b1;
        prod_k  = SEL_W'(k);
        prod_ld = slots_i[k-1].ld;
      end
    end
  end

  // Load data becomes forwardable only once it reaches slot LOAD_LAT+1.
  assign ready = !prod_ld || (prod_k >= SEL_W'(LOAD_LAT + 1));

  // Forward when allowed and ready, otherwise request a stall.
  always_comb begin
    sel_o       = SEL_W'(FWD_REGFILE);
    stall_req_o = 1'b0;
    if (FWD_EN != 0) begin
      if (found && ready) begin
        sel_o = prod_k;
      end else begin
        stall_req_o = found;
      end
    end else begin
      stall_req_o = found;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside EX: shift register of in-flight writers, per-source
// forward selects, a combined stall and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int REG_W     = 5,
  parameter  int NUM_SRC   = 2,
  parameter  int LOAD_LAT  = 1,
  parameter  int FWD_EN    = 1,
  parameter  int ZERO_SKIP = 1,
  localparam int DEPTH     = LOAD_LAT + 1,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ex_valid,
  input  logic                            ex_flush,
  input  logic [REG_W-1:0]                ex_rd,
  input  logic                            ex_we,
  input  logic                            ex_ld,
  input  logic [NUM_SRC-1:0][REG_W-1:0]   ex_rs,
  input  logic [NUM_SRC-1:0]              ex_rs_used,
  output logic                            stall,
  output logic [NUM_SRC-1:0][SEL_W-1:0]   fwd_sel,
  output logic [31:0]                     stall_cnt
);

  // slots_q[k-1] holds slot k; slot 1 is MEM, slot DEPTH is WB.
  slot_t [DEPTH-1:0]  slots_q, slots_d;
  logic [NUM_SRC-1:0] stall_req;
  logic [31:0]        stall_cnt_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    src_resolve #(
      .REG_W    (REG_W),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .FWD_EN   (FWD_EN),
      .ZERO_SKIP(ZERO_SKIP),
      .SEL_W    (SEL_W)
    ) u_src_resolve (
      .rs_i       (ex_rs[i]),
      .rs_used_i  (ex_rs_used[i]),
      .slots_i    (slots_q),
      .sel_o      (fwd_sel[i]),
      .stall_req_o(stall_req[i])
    );
  end

  // A killed or empty EX slot never holds the front end.
  assign stall = (|stall_req) && ex_valid && !ex_flush;

  // Next slot contents: EX enters slot 1 only when it advances; older slots always shift.
  always_comb begin
    slots_d    = '0;
    if (ex_valid && !ex_flush && !stall) begin
      slots_d[0].valid = 1'b1;
      slots_d[0].rd    = RD_W_MAX'(ex_rd);
      slots_d[0].we    = ex_we;
      slots_d[0].ld    = ex_ld;
    end
    for (int k = 1; k < DEPTH; k++) begin
      slots_d[k] = slots_q[k-1];
    end
  end

  // Slot register; reset forgets everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
    end else begin
      slots_q <= slots_d;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three configurations share one
// stimulus stream; each step pushes its expectation and the sampled outputs
// of the targeted configuration are popped and compared mid-cycle.
module tb_hazard_scoreboard;

  localparam int IA = 0;  // defaults
  localparam int IB = 1;  // LOAD_LAT = 3
  localparam int IC = 2;  // FWD_EN = 0

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid, ex_flush, ex_we, ex_ld;
  logic [4:0]       ex_rd;
  logic [1:0][4:0]  ex_rs;
  logic [1:0]       ex_rs_used;

  logic             stall_a, stall_b, stall_c;
  logic [1:0][1:0]  sel_a, sel_c;
  logic [1:0][2:0]  sel_b;
  logic [31:0]      cnt_a, cnt_b, cnt_c;

  typedef struct {
    string       tag;
    int          inst;
    logic        stall;
    logic [2:0]  sel0;
    logic [2:0]  sel1;
    bit          chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_ld(ex_ld), .ex_rs(ex_rs),
    .ex_rs_used(ex_rs_used), .stall(stall_a), .fwd_sel(sel_a), .stall_cnt(cnt_a)
  );

  hazard_scoreboard #(.LOAD_LAT(3)) u_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_ld(ex_ld), .ex_rs(ex_rs),
    .ex_rs_used(ex_rs_used), .stall(stall_b), .fwd_sel(sel_b), .stall_cnt(cnt_b)
  );

  hazard_scoreboard #(.FWD_EN(0)) u_c (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_ld(ex_ld), .ex_rs(ex_rs),
    .ex_rs_used(ex_rs_used), .stall(stall_c), .fwd_sel(sel_c), .stall_cnt(cnt_c)
  );

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ex_valid = 1'b0; ex_flush = 1'b0; ex_we = 1'b0; ex_ld = 1'b0;
    ex_rd = '0; ex_rs = '0; ex_rs_used = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive one EX cycle, push its expectation, then pop and check at negedge.
  task automatic step(input int inst, input string tag,
                      input logic v, input logic fl, input logic [4:0] rd,
                      input logic we, input logic ld,
                      input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [1:0] used,
                      input logic e_stall, input logic [2:0] e_sel0,
                      input logic [2:0] e_sel1,
                      input bit chk_cnt, input logic [31:0] e_cnt,
                      input logic r = 1'b0);
    exp_t e, o;
    @(posedge clk); #1;
    rst = r; ex_valid = v; ex_flush = fl; ex_rd = rd; ex_we = we; ex_ld = ld;
    ex_rs[0] = rs0; ex_rs[1] = rs1; ex_rs_used = used;
    e.tag = tag; e.inst = inst; e.stall = e_stall; e.sel0 = e_sel0;
    e.sel1 = e_sel1; e.chk_cnt = chk_cnt; e.cnt = e_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    o = exp_q.pop_front();
    case (o.inst)
      IA: begin
        e.stall = stall_a; e.sel0 = {1'b0, sel_a[0]}; e.sel1 = {1'b0, sel_a[1]}; e.cnt = cnt_a;
      end
      IB: begin
        e.stall = stall_b; e.sel0 = sel_b[0]; e.sel1 = sel_b[1]; e.cnt = cnt_b;
      end
      default: begin
        e.stall = stall_c; e.sel0 = {1'b0, sel_c[0]}; e.sel1 = {1'b0, sel_c[1]}; e.cnt = cnt_c;
      end
    endcase
    tests++;
    assert (e.stall === o.stall) else begin
      fails++;
      $error("FAIL %s stall: got %b want %b", o.tag, e.stall, o.stall);
    end
    tests++;
    assert (e.sel0 === o.sel0) else begin
      fails++;
      $error("FAIL %s fwd_sel0: got %0d want %0d", o.tag, e.sel0, o.sel0);
    end
    tests++;
    assert (e.sel1 === o.sel1) else begin
      fails++;
      $error("FAIL %s fwd_sel1: got %0d want %0d", o.tag, e.sel1, o.sel1);
    end
    if (o.chk_cnt) begin
      tests++;
      assert (e.cnt === o.cnt) else begin
        fails++;
        $error("FAIL %s stall_cnt: got %0d want %0d", o.tag, e.cnt, o.cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_flush = 1'b0; ex_we = 1'b0; ex_ld = 1'b0;
    ex_rd = '0; ex_rs = '0; ex_rs_used = '0;

    // ALU producer directly ahead of consumer
    do_reset();
    step(IA, "rst_idle", 1, 0, 5'd3, 1, 0, 5'd1, 5'd2, 2'b11, 0, 0, 0, 1, 0);
    step(IA, "alu_fwd",  1, 0, 5'd7, 1, 0, 5'd3, 5'd1, 2'b11, 0, 1, 0, 1, 0);

    // Load-use, default latency
    do_reset();
    step(IA, "ld_issue",   1, 0, 5'd4, 1, 1, 5'd1, 5'd2, 2'b11, 0, 0, 0, 0, 0);
    step(IA, "ld_stall",   1, 0, 5'd8, 1, 0, 5'd4, 5'd0, 2'b01, 1, 0, 0, 1, 0);
    step(IA, "ld_fwd",     1, 0, 5'd8, 1, 0, 5'd4, 5'd0, 2'b01, 0, 2, 0, 1, 1);

    // Load-use, LOAD_LAT = 3
    do_reset();
    step(IB, "ll3_issue",  1, 0, 5'd4, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IB, "ll3_st1",    1, 0, 5'd9, 1, 0, 5'd4, 5'd2, 2'b11, 1, 0, 0, 0, 0);
    step(IB, "ll3_st2",    1, 0, 5'd9, 1, 0, 5'd4, 5'd2, 2'b11, 1, 0, 0, 0, 0);
    step(IB, "ll3_st3",    1, 0, 5'd9, 1, 0, 5'd4, 5'd2, 2'b11, 1, 0, 0, 0, 0);
    step(IB, "ll3_fwd",    1, 0, 5'd9, 1, 0, 5'd4, 5'd2, 2'b11, 0, 4, 0, 1, 3);

    // Youngest producer wins; r0 never matches; unused source ignored
    do_reset();
    step(IA, "r5_a",       1, 0, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IA, "r5_b",       1, 0, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IA, "r5_young",   1, 0, 5'd0, 1, 0, 5'd5, 5'd5, 2'b11, 0, 1, 1, 0, 0);
    step(IA, "r0_skip",    1, 0, 5'd11, 1, 0, 5'd0, 5'd0, 2'b11, 0, 0, 0, 0, 0);
    step(IA, "unused_src", 1, 0, 5'd0, 0, 0, 5'd11, 5'd11, 2'b00, 0, 0, 0, 0, 0);

    // Younger load shadows a ready older ALU write
    do_reset();
    step(IA, "sh_alu",     1, 0, 5'd12, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IA, "sh_ld",      1, 0, 5'd12, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IA, "sh_stall",   1, 0, 5'd1,  1, 0, 5'd12, 5'd0, 2'b01, 1, 0, 0, 0, 0);

    // Two sources on different slots, resolved independently
    do_reset();
    step(IA, "two_alu",    1, 0, 5'd9,  1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IA, "two_ld",     1, 0, 5'd10, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IA, "two_mix",    1, 0, 5'd1,  1, 0, 5'd9, 5'd10, 2'b11, 1, 2, 0, 0, 0);
    step(IA, "two_after",  1, 0, 5'd1,  1, 0, 5'd9, 5'd10, 2'b11, 0, 0, 2, 0, 0);

    // Vector file MSB takes part in matching
    do_reset();
    step(IA, "v16_w",      1, 0, 5'd16, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IA, "v16_fwd",    1, 0, 5'd0,  0, 0, 5'd16, 5'd0, 2'b11, 0, 1, 0, 0, 0);

    // Forwarding disabled
    do_reset();
    step(IC, "nf_alu",     1, 0, 5'd6, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IC, "nf_st1",     1, 0, 5'd1, 1, 0, 5'd6, 5'd0, 2'b11, 1, 0, 0, 0, 0);
    step(IC, "nf_st2",     1, 0, 5'd1, 1, 0, 5'd6, 5'd0, 2'b11, 1, 0, 0, 0, 0);
    step(IC, "nf_go",      1, 0, 5'd1, 1, 0, 5'd6, 5'd0, 2'b11, 0, 0, 0, 1, 2);
    step(IC, "nf_v16",     1, 0, 5'd16, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IC, "nf_v16_r0",  1, 0, 5'd2,  1, 0, 5'd0, 5'd0, 2'b11, 0, 0, 0, 0, 0);

    // Flush beats stall and leaves a bubble in slot 1
    do_reset();
    step(IA, "fl_ld",      1, 0, 5'd4, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IA, "fl_kill",    1, 1, 5'd8, 1, 0, 5'd4, 5'd0, 2'b01, 0, 0, 0, 1, 0);
    step(IA, "fl_bubble",  1, 0, 5'd1, 1, 0, 5'd8, 5'd4, 2'b11, 0, 0, 2, 1, 0);

    // Reset during a load-use stall; also ex_valid gating
    do_reset();
    step(IB, "rs_ld",      1, 0, 5'd4, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0);
    step(IB, "rs_st1",     1, 0, 5'd1, 1, 0, 5'd4, 5'd0, 2'b01, 1, 0, 0, 0, 0);
    step(IB, "rs_noval",   0, 0, 5'd1, 1, 0, 5'd4, 5'd0, 2'b01, 0, 0, 0, 1, 1);
    step(IB, "rs_hit",     1, 0, 5'd1, 1, 0, 5'd4, 5'd0, 2'b01, 1, 0, 0, 1, 1, 1'b1);
    step(IB, "rs_cold",    1, 0, 5'd1, 1, 0, 5'd4, 5'd0, 2'b01, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
